lap_timer_core: RTL
===================

LAP_TIMER_CORE -- requirements
Module: lap_timer_core

Interface
REQ-001 Parameter TICK_DIV, default 500000, master_clk cycles per centisecond tick (50 MHz -> 10 ms).
REQ-002 Parameter DEB_CYCLES, default 16, consecutive synchronised low samples required to accept a beam break.
REQ-003 Parameter LOCKOUT_SEC, default 5, whole seconds after any accepted crossing during which further crossings are ignored.
REQ-004 Parameter HOLD_SEC, default 10, whole seconds after a lap during which the display shows the last lap.
REQ-005 Parameter LAP_CNT_W, default 8, width of the lap counter.
REQ-006 The block SHALL use one clock and a synchronous, active-low reset.
REQ-007 master_clk  in  1  sole clock; all state updates on its rising edge.
REQ-008 rs_n  in  1  synchronous active-low reset.
REQ-009 laser_detector  in  1  asynchronous beam input; 0 = beam broken.
REQ-010 clear  in  1  synchronous clear to idle, active high.
REQ-011 running  out  1  high in LOCK or RUN.
REQ-012 lap_strobe  out  1  one-cycle pulse per completed lap.
REQ-013 lap_count  out  LAP_CNT_W  completed laps.
REQ-014 cur_min / cur_sec / cur_cs  out  7 each  binary running lap time.
REQ-015 last_min / last_sec / last_cs  out  7 each  last completed lap time.
REQ-016 best_min / best_sec / best_cs  out  7 each, plus best_valid  out  1  fastest lap.
REQ-017 disp_min / disp_sec / disp_cs  out  7 each  time selected for the display driver.
REQ-018 overflow  out  1  current lap saturated.

Function
REQ-019 laser_detector SHALL pass a 2-flop synchroniser; the debounced state goes broken after DEB_CYCLES consecutive low synchronised samples and clear after DEB_CYCLES consecutive high samples.
REQ-020 A crossing event SHALL be the cycle the debounced state goes broken; latency from the laser_detector falling edge to the event = DEB_CYCLES+2 cycles; pulses shorter than DEB_CYCLES cycles produce no event.
REQ-021 FSM states: IDLE, LOCK, RUN.
REQ-022 IDLE: time and prescaler held at 0; a crossing zeroes time and prescaler and enters LOCK; lap_count is unchanged.
REQ-023 LOCK: time runs; crossings are ignored; the FSM enters RUN when cur_sec reaches LOCKOUT_SEC with cur_min == 0.
REQ-024 RUN: a crossing SHALL, in the same cycle, pulse lap_strobe, latch cur_* into last_*, zero cur_* and the prescaler, increment lap_count (saturating at all ones), clear overflow and enter LOCK.
REQ-025 The prescaler counts 0..TICK_DIV-1 and issues one tick on its terminal count; each tick increments cs 0..99, carrying to sec 0..59, carrying to min 0..99.
REQ-026 At 99:59.99 the time SHALL hold and overflow SHALL assert until the next lap, clear or reset.
REQ-027 disp_* SHALL equal last_* while lap_count != 0, cur_min == 0 and cur_sec < HOLD_SEC; otherwise disp_* equals cur_*; disp_* is registered with one cycle of latency.
REQ-028 clear SHALL zero all outputs, the debouncer state and the FSM (to IDLE) on the next edge; clear takes priority over a simultaneous crossing.

Reset
REQ-029 With rs_n low at a clock edge, every output and internal register SHALL be 0 and the FSM SHALL enter IDLE; the debounced state resets to beam-clear.
REQ-030 Reset taken mid-lap SHALL discard all lap data; no lap_strobe is generated.

Configuration
REQ-031 Macro LAP_TIMER_BEST_LAP_EN: when defined, on each lap best_* SHALL load last-lap time if best_valid == 0 or the new lap is strictly shorter (compared as min, then sec, then cs), and best_valid is set.
REQ-032 When LAP_TIMER_BEST_LAP_EN is undefined, best_* and best_valid SHALL be constant 0, no comparison logic is built, and the ports remain present.

Verification (TICK_DIV=4, DEB_CYCLES=2, LOCKOUT_SEC=1, HOLD_SEC=2)
REQ-033 rs_n low for 3 cycles with laser_detector toggling -> all outputs 0, running 0, no lap_strobe.
REQ-034 laser_detector low for 1 cycle, then high -> no event; low for 2+ cycles -> running = 1 exactly 4 cycles after the falling edge, and cur_cs increments every 4 cycles.
REQ-035 Second crossing at 0.50 s -> ignored (LOCK); crossing at 3.25 s -> lap_strobe pulses one cycle, last = 0:03.25, lap_count = 1, cur = 0, disp = 0:03.25 until cur reaches 0:02.00, then disp follows cur.
REQ-036 Laps of 3.25 s, 4.00 s and 2.50 s -> best = 3.25, then 3.25, then 2.50 with best_valid = 1; with the macro undefined -> best stays 0.
REQ-037 Preload the counters to 99:59.98 and run 3 ticks -> the time holds at 99:59.99 with overflow = 1; the next lap latches 99:59.99 and clears overflow.
REQ-038 clear asserted in the same cycle as an accepted crossing in RUN -> no lap_strobe, FSM in IDLE, all outputs 0.

Source files
------------

// File: rtl/lap_timer_core.sv
// Beam-break lap timer: synchronised/debounced crossing detector, IDLE/LOCK/RUN sequencer,
// min:sec:cs lap clock with last/display registers. Best-lap tracking is built under LAP_TIMER_BEST_LAP_EN.
module lap_timer_core #(
  parameter int TICK_DIV    = 500000,
  parameter int DEB_CYCLES  = 16,
  parameter int LOCKOUT_SEC = 5,
  parameter int HOLD_SEC    = 10,
  parameter int LAP_CNT_W   = 8
) (
  input  logic                 master_clk,
  input  logic                 rs_n,
  input  logic                 laser_detector,
  input  logic                 clear,
  output logic                 running,
  output logic                 lap_strobe,
  output logic [LAP_CNT_W-1:0] lap_count,
  output logic [6:0]           cur_min,
  output logic [6:0]           cur_sec,
  output logic [6:0]           cur_cs,
  output logic [6:0]           last_min,
  output logic [6:0]           last_sec,
  output logic [6:0]           last_cs,
  output logic [6:0]           best_min,
  output logic [6:0]           best_sec,
  output logic [6:0]           best_cs,
  output logic                 best_valid,
  output logic [6:0]           disp_min,
  output logic [6:0]           disp_sec,
  output logic [6:0]           disp_cs,
  output logic                 overflow
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LOCK, RUN} state_t;
  state_t state, state_nx;

  logic          brk_s1, brk_s2, deb_brk;
  logic [DW-1:0] deb_cnt;
  logic          crossing, lap_evt, tick, at_max, near_max, hold;
  logic [PW-1:0] pre;

  // Sync flops store "beam broken" so their all-zero reset value reads as beam-clear.
  always_ff @(posedge master_clk) begin
    if (!rs_n || clear) begin
      brk_s1  <= 1'b0;
      brk_s2  <= 1'b0;
      deb_brk <= 1'b0;
      deb_cnt <= '0;
    end else begin
      brk_s1 <= ~laser_detector;
      brk_s2 <= brk_s1;
      if (brk_s2 == deb_brk)
        deb_cnt <= '0;
      else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
        deb_cnt <= '0;
        deb_brk <= brk_s2;
      end else
        deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign crossing = brk_s2 && !deb_brk && (deb_cnt == DW'(DEB_CYCLES - 1));
  assign lap_evt  = (state == RUN) && crossing;
  assign tick     = (pre == PW'(TICK_DIV - 1));
  assign at_max   = (cur_min == 7'd99) && (cur_sec == 7'd59) && (cur_cs == 7'd99);
  assign near_max = (cur_min == 7'd99) && (cur_sec == 7'd59) && (cur_cs == 7'd98);
  assign hold     = (lap_count != '0) && (cur_min == '0) && (cur_sec < 7'(HOLD_SEC));
  assign running  = (state != IDLE);

  always_ff @(posedge master_clk) begin
    if (!rs_n || clear) state <= IDLE;
    else                state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (crossing) state_nx = LOCK;
      LOCK:    if ((cur_min == '0) && (cur_sec >= 7'(LOCKOUT_SEC))) state_nx = RUN;
      RUN:     if (crossing) state_nx = LOCK;
      default: state_nx = IDLE;
    endcase
  end

  // Lap clock; saturates at 99:59.99 and flags overflow on the tick that lands there.
  always_ff @(posedge master_clk) begin
    if (!rs_n || clear || (state == IDLE) || lap_evt) begin
      pre      <= '0;
      cur_min  <= '0;
      cur_sec  <= '0;
      cur_cs   <= '0;
      overflow <= 1'b0;
    end else if (tick) begin
      pre <= '0;
      if (at_max || near_max) overflow <= 1'b1;
      if (!at_max) begin
        if (cur_cs != 7'd99)
          cur_cs <= cur_cs + 1'b1;
        else begin
          cur_cs <= '0;
          if (cur_sec != 7'd59)
            cur_sec <= cur_sec + 1'b1;
          else begin
            cur_sec <= '0;
            cur_min <= cur_min + 1'b1;
          end
        end
      end
    end else
      pre <= pre + 1'b1;
  end

  always_ff @(posedge master_clk) begin
    if (!rs_n || clear) begin
      lap_strobe <= 1'b0;
      lap_count  <= '0;
      last_min   <= '0;
      last_sec   <= '0;
      last_cs    <= '0;
      disp_min   <= '0;
      disp_sec   <= '0;
      disp_cs    <= '0;
    end else begin
      lap_strobe <= lap_evt;
      if (lap_evt) begin
        last_min <= cur_min;
        last_sec <= cur_sec;
        last_cs  <= cur_cs;
        if (lap_count != '1) lap_count <= lap_count + 1'b1;
      end
      disp_min <= hold ? last_min : cur_min;
      disp_sec <= hold ? last_sec : cur_sec;
      disp_cs  <= hold ? last_cs  : cur_cs;
    end
  end

`ifdef LAP_TIMER_BEST_LAP_EN
  logic faster;
  // Fields are range-bounded, so a concatenated compare orders min, then sec, then cs.
  assign faster = {cur_min, cur_sec, cur_cs} < {best_min, best_sec, best_cs};

  always_ff @(posedge master_clk) begin
    if (!rs_n || clear) begin
      best_min   <= '0;
      best_sec   <= '0;
      best_cs    <= '0;
      best_valid <= 1'b0;
    end else if (lap_evt && (!best_valid || faster)) begin
      best_min   <= cur_min;
      best_sec   <= cur_sec;
      best_cs    <= cur_cs;
      best_valid <= 1'b1;
    end
  end
`else
  assign best_min   = '0;
  assign best_sec   = '0;
  assign best_cs    = '0;
  assign best_valid = 1'b0;
`endif
endmodule
